// File: rtl/pipeline_sequencer_pkg.sv
// Shared definitions for the pipeline sequencer: state encoding, default
// sizes and a helper that classifies the states that advance the pipeline.
package pipeline_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } seq_state_t;

    localparam int unsigned NB_CYCLE_COUNT_DEF = 32;
    localparam int unsigned DRAIN_CYCLES_DEF   = 3;

    // States in which the downstream stages clock forward.
    function automatic logic is_advance_state(input seq_state_t s);
        return (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/pipeline_sequencer_cycle_counter.sv
// Free-running executed-cycle counter with enable, synchronous clear and
// asynchronous active-low reset; wraps modulo 2^NB_CYCLE_COUNT.
module pipeline_sequencer_cycle_counter #(
    parameter int unsigned NB_CYCLE_COUNT = 32
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_enable,
    input  logic                      i_clear,
    output logic [NB_CYCLE_COUNT-1:0] o_count
);

    // Count enabled cycles; clear wins over enable.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_count <= '0;
        end else if (i_clear) begin
            o_count <= '0;
        end else if (i_enable) begin
            o_count <= o_count + NB_CYCLE_COUNT'(1);
        end
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Central run/step/stall/flush/drain controller for the 5-stage pipeline.
// Stage enables, flush and bubble are Mealy outputs so hazards act in the
// same cycle; state, drain counter, step_done and halted are registered.
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int unsigned NB_CYCLE_COUNT = NB_CYCLE_COUNT_DEF,
    parameter int unsigned DRAIN_CYCLES   = DRAIN_CYCLES_DEF
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_run,
    input  logic                      i_step,
    input  logic                      i_clear,
    input  logic                      i_risk_detected,
    input  logic                      i_if_flush,
    input  logic                      i_halt_detected,
    output logic                      o_pc_enable,
    output logic                      o_if_id_enable,
    output logic                      o_id_ex_enable,
    output logic                      o_ex_mem_enable,
    output logic                      o_mem_wb_enable,
    output logic                      o_if_id_flush,
    output logic                      o_id_ex_bubble,
    output logic                      o_step_done,
    output logic                      o_halted,
    output logic [NB_CYCLE_COUNT-1:0] o_cycle_count
);

    localparam int unsigned NB_DRAIN = $clog2(DRAIN_CYCLES) + 1;
    localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES - 1);

    seq_state_t          state;
    logic [NB_DRAIN-1:0] drain_cnt;
    logic                adv;
    logic                front_adv;

    // Stage controls from current state and hazard inputs; a clear cycle never advances.
    always_comb begin
        adv             = is_advance_state(state) & ~i_clear;
        front_adv       = adv & (state != ST_DRAIN);
        o_id_ex_enable  = adv;
        o_ex_mem_enable = adv;
        o_mem_wb_enable = adv;
        o_pc_enable     = front_adv & ~i_risk_detected;
        o_if_id_enable  = front_adv & ~i_risk_detected;
        o_id_ex_bubble  = front_adv & i_risk_detected;
        o_if_id_flush   = front_adv & i_if_flush & ~i_risk_detected;
    end

    // Sequencer FSM with registered step_done/halted and the drain down-counter.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= ST_IDLE;
            drain_cnt   <= '0;
            o_step_done <= 1'b0;
            o_halted    <= 1'b0;
        end else if (i_clear) begin
            state       <= ST_IDLE;
            drain_cnt   <= '0;
            o_step_done <= 1'b0;
            o_halted    <= 1'b0;
        end else begin
            o_step_done <= 1'b0;
            o_halted    <= (state == ST_HALTED);
            case (state)
                ST_IDLE: begin
                    if (i_run) begin
                        state <= ST_RUN;
                    end else if (i_step) begin
                        state <= ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (i_halt_detected && !i_risk_detected) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end else if (!i_run) begin
                        state <= ST_IDLE;
                    end
                end
                ST_STEP: begin
                    if (i_halt_detected && !i_risk_detected) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end else begin
                        state       <= ST_IDLE;
                        o_step_done <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state       <= ST_HALTED;
                        o_step_done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - NB_DRAIN'(1);
                    end
                end
                ST_HALTED: begin
                    state <= ST_HALTED;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    pipeline_sequencer_cycle_counter #(
        .NB_CYCLE_COUNT(NB_CYCLE_COUNT)
    ) u_cycle_counter (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_enable  (adv),
        .i_clear   (i_clear),
        .o_count   (o_cycle_count)
    );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: per-cycle vector table with a
// scoreboard queue, plus hand-written reset, step-halt and wrap sequences.
module tb_pipeline_sequencer;

    logic        clk;
    logic        rst_n;
    logic        run, step, clr, risk, flsh, halt;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_bubble, step_done, halted;
    logic [31:0] cnt;
    logic [8:0]  outs;

    logic        w_run;
    logic        w_pc, w_ifid, w_idex, w_exmem, w_memwb, w_flush, w_bubble, w_sd, w_halted;
    logic [3:0]  w_cnt;

    int passed = 0;
    int total  = 0;

    localparam logic [8:0] O_Z     = 9'b00000_0000;
    localparam logic [8:0] O_RUN   = 9'b11111_0000;
    localparam logic [8:0] O_STALL = 9'b00111_0100;
    localparam logic [8:0] O_FLUSH = 9'b11111_1000;
    localparam logic [8:0] O_DRN   = 9'b00111_0000;
    localparam logic [8:0] O_SD    = 9'b00000_0010;
    localparam logic [8:0] O_HLT   = 9'b00000_0001;

    typedef struct {
        logic [5:0]  in;   // {run, step, clear, risk, if_flush, halt}
        logic [8:0]  out;  // {pc, if_id, id_ex, ex_mem, mem_wb, flush, bubble, step_done, halted}
        logic [31:0] cnt;
    } vec_t;

    typedef struct {
        logic [8:0]  out;
        logic [31:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    pipeline_sequencer dut (
        .i_clock         (clk),
        .i_reset_n       (rst_n),
        .i_run           (run),
        .i_step          (step),
        .i_clear         (clr),
        .i_risk_detected (risk),
        .i_if_flush      (flsh),
        .i_halt_detected (halt),
        .o_pc_enable     (pc_en),
        .o_if_id_enable  (ifid_en),
        .o_id_ex_enable  (idex_en),
        .o_ex_mem_enable (exmem_en),
        .o_mem_wb_enable (memwb_en),
        .o_if_id_flush   (ifid_flush),
        .o_id_ex_bubble  (idex_bubble),
        .o_step_done     (step_done),
        .o_halted        (halted),
        .o_cycle_count   (cnt)
    );

    pipeline_sequencer #(
        .NB_CYCLE_COUNT(4),
        .DRAIN_CYCLES  (3)
    ) dut_w (
        .i_clock         (clk),
        .i_reset_n       (rst_n),
        .i_run           (w_run),
        .i_step          (1'b0),
        .i_clear         (1'b0),
        .i_risk_detected (1'b0),
        .i_if_flush      (1'b0),
        .i_halt_detected (1'b0),
        .o_pc_enable     (w_pc),
        .o_if_id_enable  (w_ifid),
        .o_id_ex_enable  (w_idex),
        .o_ex_mem_enable (w_exmem),
        .o_mem_wb_enable (w_memwb),
        .o_if_id_flush   (w_flush),
        .o_id_ex_bubble  (w_bubble),
        .o_step_done     (w_sd),
        .o_halted        (w_halted),
        .o_cycle_count   (w_cnt)
    );

    assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_flush, idex_bubble, step_done, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic add(input logic [5:0] in, input logic [8:0] o, input int c);
        vec_t v;
        v.in  = in;
        v.out = o;
        v.cnt = c;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [5:0] in);
        {run, step, clr, risk, flsh, halt} = in;
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0;
        w_run = 1'b0;
        drive(6'b000000);

        add(6'b000000, O_Z, 0);
        add(6'b100000, O_Z, 0);
        for (int i = 0; i < 10; i++) add(6'b100000, O_RUN, i);
        add(6'b100100, O_STALL, 10);
        add(6'b100110, O_STALL, 11);
        add(6'b100010, O_FLUSH, 12);
        add(6'b000000, O_RUN, 13);
        add(6'b001000, O_Z, 14);
        add(6'b010000, O_Z, 0);
        add(6'b000000, O_RUN, 0);
        add(6'b010000, O_SD, 1);
        add(6'b000000, O_RUN, 1);
        add(6'b010000, O_SD, 2);
        add(6'b000000, O_RUN, 2);
        add(6'b000000, O_SD, 3);
        add(6'b110000, O_Z, 3);
        add(6'b100000, O_RUN, 3);
        add(6'b100001, O_RUN, 4);
        add(6'b110000, O_DRN, 5);
        add(6'b010000, O_DRN, 6);
        add(6'b010000, O_DRN, 7);
        add(6'b010000, O_SD, 8);
        add(6'b110000, O_HLT, 8);
        add(6'b001000, O_HLT, 8);
        add(6'b000000, O_Z, 0);
        add(6'b100000, O_Z, 0);
        add(6'b100000, O_RUN, 0);
        add(6'b101000, O_Z, 1);
        add(6'b000000, O_Z, 0);
        add(6'b100000, O_Z, 0);
        add(6'b100101, O_STALL, 0);
        add(6'b000000, O_RUN, 1);
        add(6'b000000, O_Z, 2);

        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].in);
            e.out = vecs[i].out;
            e.cnt = vecs[i].cnt;
            sb.push_back(e);
            #2;
            e = sb.pop_front();
            chk($sformatf("v%0d_out", i), 32'(outs), 32'(e.out));
            chk($sformatf("v%0d_cnt", i), cnt, e.cnt);
        end

        // Asynchronous reset in the middle of DRAIN.
        @(negedge clk); drive(6'b100000);
        @(negedge clk); drive(6'b100001);
        @(negedge clk); drive(6'b000000);
        #2;
        chk("drain_before_reset", 32'(outs), 32'(O_DRN));
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_outs", 32'(outs), 32'(O_Z));
        chk("async_reset_cnt", cnt, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        #2;
        chk("post_reset_idle", 32'(outs), 32'(O_Z));

        // Step into a HALT: drain, then step_done on drain completion.
        @(negedge clk); drive(6'b010000);
        @(negedge clk); drive(6'b000001);
        #2;
        chk("step_halt_adv", 32'(outs), 32'(O_RUN));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drive(6'b000000);
            #2;
            chk($sformatf("step_drain%0d", k), 32'(outs), 32'(O_DRN));
        end
        @(negedge clk);
        #2;
        chk("step_drain_done", 32'(outs), 32'(O_SD));
        chk("step_drain_cnt", cnt, 32'd4);
        @(negedge clk);
        #2;
        chk("step_halted", 32'(outs), 32'(O_HLT));
        @(negedge clk); drive(6'b001000);
        @(negedge clk); drive(6'b000000);
        #2;
        chk("clear_cnt", cnt, 32'd0);
        chk("clear_outs", 32'(outs), 32'(O_Z));

        // Counter wrap on a 4-bit instance.
        @(negedge clk); w_run = 1'b1;
        repeat (16) @(posedge clk);
        #2;
        chk("wrap_max", 32'(w_cnt), 32'd15);
        @(posedge clk);
        #2;
        chk("wrap_zero", 32'(w_cnt), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
